lsu_ctrl: RTL and testbench

//  Load/store sequencer between decode/execute and the data-memory port. Takes one decoded
//  mem op (valid, mem_wen, func3) plus EXU address and rs2 data, runs a req/gnt/rvalid bus

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared func3 codes, FSM state encoding and width helpers for the LSU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] LSU_F3_B  = 3'd0;
    localparam logic [2:0] LSU_F3_H  = 3'd1;
    localparam logic [2:0] LSU_F3_W  = 3'd2;
    localparam logic [2:0] LSU_F3_BU = 3'd4;
    localparam logic [2:0] LSU_F3_HU = 3'd5;

    localparam logic [1:0] LSU_SZ_B = 2'd0;
    localparam logic [1:0] LSU_SZ_H = 2'd1;
    localparam logic [1:0] LSU_SZ_W = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    // Unused codes 3/6/7 fall into the word bucket.
    function automatic logic [1:0] lsu_size(input logic [2:0] func3);
        case (func3)
            LSU_F3_B, LSU_F3_BU: lsu_size = LSU_SZ_B;
            LSU_F3_H, LSU_F3_HU: lsu_size = LSU_SZ_H;
            LSU_F3_W:            lsu_size = LSU_SZ_W;
            default:             lsu_size = LSU_SZ_W;
        endcase
    endfunction

    function automatic logic lsu_is_signed(input logic [2:0] func3);
        lsu_is_signed = (func3 == LSU_F3_B) || (func3 == LSU_F3_H);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational byte-lane alignment: store mask/shift and load extract/extend.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      st_func3_i,
    input  logic [1:0]      st_off_i,
    input  logic [XLEN-1:0] st_wdata_i,
    output logic [7:0]      st_wmask_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic [2:0]      ld_func3_i,
    input  logic [1:0]      ld_off_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] w_ld_shift;
    logic            w_ld_sx;

    always_comb begin
        case (lsu_size(st_func3_i))
            LSU_SZ_B: st_wmask_o = 8'h01 << st_off_i;
            LSU_SZ_H: st_wmask_o = 8'h03 << st_off_i;
            default:  st_wmask_o = 8'h0f;
        endcase
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
    end

    // Lanes past the word shift in as zero; a half at offset 3 only has one
    // real byte, so its sign comes from that byte.
    always_comb begin
        w_ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
        w_ld_sx    = lsu_is_signed(ld_func3_i);
        case (lsu_size(ld_func3_i))
            LSU_SZ_B: ld_data_o = {{(XLEN-8){w_ld_sx & w_ld_shift[7]}}, w_ld_shift[7:0]};
            LSU_SZ_H: begin
                if (ld_off_i == 2'd3) begin
                    ld_data_o = {{(XLEN-8){w_ld_sx & w_ld_shift[7]}}, w_ld_shift[7:0]};
                end else begin
                    ld_data_o = {{(XLEN-16){w_ld_sx & w_ld_shift[15]}}, w_ld_shift[15:0]};
                end
            end
            default:  ld_data_o = w_ld_shift;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Single-outstanding load/store sequencer over a req/gnt/rvalid bus.
//            Optional misalignment trap: `LSU_MISALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [2:0]        in_func3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_e        state_q;
    logic              wen_q;
    logic [2:0]        func3_q;
    logic [1:0]        off_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_rdata_q;
    logic              out_err_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [7:0]        mem_wmask_q;

    logic [7:0]        w_st_wmask;
    logic [XLEN-1:0]   w_st_wdata;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_misalign;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_func3_i (in_func3),
        .st_off_i   (in_addr[1:0]),
        .st_wdata_i (in_wdata),
        .st_wmask_o (w_st_wmask),
        .st_wdata_o (w_st_wdata),
        .ld_func3_i (func3_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (mem_rdata),
        .ld_data_o  (w_ld_data)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = ((lsu_size(in_func3) == LSU_SZ_H) && in_addr[0]) ||
                        ((lsu_size(in_func3) == LSU_SZ_W) && (in_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            wen_q       <= 1'b0;
            func3_q     <= 3'd0;
            off_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= 8'h0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (in_valid) begin
                        wen_q      <= in_wen;
                        func3_q    <= in_func3;
                        off_q      <= in_addr[1:0];
                        in_ready_q <= 1'b0;
                        if (w_misalign) begin
                            state_q     <= LSU_RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_rdata_q <= '0;
                        end else begin
                            state_q     <= LSU_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= in_wen;
                            mem_addr_q  <= {in_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= in_wen ? w_st_wdata : '0;
                            mem_wmask_q <= in_wen ? w_st_wmask : 8'h0;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (wen_q) begin
                            state_q     <= LSU_RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b0;
                            out_rdata_q <= '0;
                        end else begin
                            state_q <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid) begin
                        state_q     <= LSU_RESP;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        out_rdata_q <= w_ld_data;
                    end
                end
                LSU_RESP: begin
                    state_q    <= LSU_IDLE;
                    in_ready_q <= 1'b1;
                    out_err_q  <= 1'b0;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_rdata = out_rdata_q;
    assign out_err   = out_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Self-checking bench for lsu_ctrl with a cycle-timeline reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen;
    logic [2:0]  in_func3;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_err;
    logic [31:0] out_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    lsu_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: what the op must look like on each cycle
    bit          mon_en = 1'b0;
    bit          m_active = 1'b0;
    bit          m_err, m_load;
    int          m_start, m_g, m_r, m_done;
    logic [31:0] m_addr, m_wdata, m_rdata, m_raw;
    logic [7:0]  m_wmask;

    function automatic int width_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [7:0] exp_mask(input logic [2:0] f3, input logic [1:0] off);
        int n;
        int m;
        n = width_of(f3);
        if (n == 4) return 8'h0f;
        m = ((1 << n) - 1) << off;
        return m[7:0];
    endfunction

    function automatic logic [31:0] exp_sdata(input logic [31:0] wd, input logic [1:0] off);
        logic [63:0] t;
        t = {32'd0, wd} << (8 * int'(off));
        return t[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b[4];
        logic [31:0] v;
        int n, have, o;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        o    = int'(off);
        n    = width_of(f3);
        have = (n < 4 - o) ? n : 4 - o;
        v    = 32'd0;
        for (int i = 0; i < have; i++) v = v | (32'(b[o+i]) << (8 * i));
        if ((f3 == 3'd0 || f3 == 3'd1) && b[o+have-1][7])
            for (int k = 8 * have; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    function automatic bit exp_misalign(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return (width_of(f3) == 2 && a[0]) || (width_of(f3) == 4 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Bus responder for cycle `rel` of the current op, with stray handshakes
    // wherever the controller is supposed to ignore them.
    task automatic drive_env(input int rel);
        bit req_win, wait_win, gnt_now, rv_now;
        req_win  = !m_err && rel >= 1 && rel <= 1 + m_g;
        gnt_now  = !m_err && rel == 1 + m_g;
        wait_win = m_load && !m_err && rel >= 2 + m_g && rel <= 2 + m_g + m_r;
        rv_now   = m_load && !m_err && rel == 2 + m_g + m_r;
        mem_gnt    = gnt_now | (!req_win && ($urandom_range(0, 3) == 0));
        mem_rvalid = rv_now | (!wait_win && ($urandom_range(0, 3) == 0));
        mem_rdata  = rv_now ? m_raw : $urandom;
    endtask

    task automatic run_op(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int g, input int r, input bit hold);
        @(negedge clk);
        in_valid = 1'b1;
        in_wen   = wen;
        in_func3 = f3;
        in_addr  = addr;
        in_wdata = wd;
        m_err    = exp_misalign(f3, addr);
        m_load   = !wen;
        m_g      = g;
        m_r      = r;
        m_raw    = rd;
        m_addr   = {addr[31:2], 2'b00};
        m_wmask  = wen ? exp_mask(f3, addr[1:0]) : 8'h0;
        m_wdata  = wen ? exp_sdata(wd, addr[1:0]) : 32'd0;
        m_rdata  = (wen || m_err) ? 32'd0 : exp_load(f3, addr[1:0], rd);
        m_done   = m_err ? 1 : (wen ? 2 + g : 3 + g + r);
        m_start  = cyc;
        m_active = 1'b1;
        drive_env(0);
        for (int rel = 1; rel <= m_done; rel++) begin
            @(negedge clk);
            in_valid = hold;
            drive_env(rel);
        end
    endtask

    // ---------------- compare process
    int          ov_count = 0;
    int          req_cycles = 0;
    logic [31:0] lst_rdata, lst_addr, lst_wdata;
    logic [7:0]  lst_wmask;
    logic        lst_err;

    always begin : p_cmp
        int rel;
        bit in_op, e_req, e_ov;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            ov_count++;
            lst_rdata = out_rdata;
            lst_err   = out_err;
        end
        if (mem_req === 1'b1) begin
            req_cycles++;
            lst_addr  = mem_addr;
            lst_wdata = mem_wdata;
            lst_wmask = mem_wmask;
        end
        if (mon_en) begin
            rel   = cyc - m_start;
            in_op = m_active && rel >= 1 && rel <= m_done;
            e_req = in_op && !m_err && rel <= 1 + m_g;
            e_ov  = m_active && rel == m_done;
            chk("in_ready", 32'(in_ready), 32'(!in_op));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("out_err", 32'(out_err), 32'(e_ov && m_err));
            if (e_req) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 32'(mem_we), 32'(!m_load));
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
            end
            if (e_ov) chk("out_rdata", out_rdata, m_rdata);
        end
    end

    task automatic abort_op(input int at);
        int o0;
        @(negedge clk);
        mon_en     = 1'b0;
        in_valid   = 1'b1;
        in_wen     = 1'b0;
        in_func3   = 3'd2;
        in_addr    = 32'h0000_0100;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        if (at == 2) begin
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
        end
        chk("abort_req_before", 32'(mem_req), 32'(at == 1));
        rst = 1'b1;
        #1;
        chk("abort_req_drop", 32'(mem_req), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        o0  = ov_count;
        repeat (3) begin
            @(negedge clk);
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("abort_no_valid", 32'(ov_count - o0), 32'd0);
        chk("abort_idle_ready", 32'(in_ready), 32'd1);
        chk("abort_idle_req", 32'(mem_req), 32'd0);
        m_active = 1'b0;
        mon_en   = 1'b1;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int r0, o0;
        rst = 1'b1;
        in_valid = 1'b0; in_wen = 1'b0; in_func3 = 3'd0;
        in_addr = 32'd0; in_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        run_op(1'b1, 3'd0, 32'h8000_0003, 32'h1234_56AB, 32'd0, 0, 0, 1'b0);
        chk("t1_wmask", 32'(lst_wmask), 32'h0000_0008);
        chk("t1_wdata", lst_wdata, 32'hAB00_0000);
        chk("t1_addr", lst_addr, 32'h8000_0000);

        run_op(1'b0, 3'd0, 32'h0000_1002, 32'd0, 32'h0080_0000, 0, 0, 1'b0);
        chk("t2_lb", lst_rdata, 32'hFFFF_FF80);
        run_op(1'b0, 3'd4, 32'h0000_1002, 32'd0, 32'h0080_0000, 0, 0, 1'b0);
        chk("t2_lbu", lst_rdata, 32'h0000_0080);

        r0 = req_cycles;
        o0 = ov_count;
        run_op(1'b0, 3'd2, 32'h0000_2000, 32'd0, 32'hCAFE_F00D, 3, 1, 1'b0);
        chk("t3_req_cycles", 32'(req_cycles - r0), 32'd4);
        chk("t3_one_valid", 32'(ov_count - o0), 32'd1);
        chk("t3_rdata", lst_rdata, 32'hCAFE_F00D);

        abort_op(1);
        abort_op(2);

`ifdef LSU_MISALIGN_CHECK_EN
        r0 = req_cycles;
        run_op(1'b0, 3'd2, 32'h0000_3002, 32'd0, 32'h1111_2222, 0, 0, 1'b0);
        chk("t5_err", 32'(lst_err), 32'd1);
        chk("t5_no_req", 32'(req_cycles - r0), 32'd0);
        chk("t5_rdata", lst_rdata, 32'd0);
`else
        run_op(1'b0, 3'd1, 32'h0000_3003, 32'd0, 32'hFF00_0000, 0, 0, 1'b0);
        chk("t5_lh_off3", lst_rdata, 32'hFFFF_FFFF);
        run_op(1'b0, 3'd5, 32'h0000_3003, 32'd0, 32'hFF00_0000, 0, 0, 1'b0);
        chk("t5_lhu_off3", lst_rdata, 32'h0000_00FF);
`endif

        run_op(1'b1, 3'd2, 32'h0000_0040, 32'hDEAD_BEEF, 32'd0, 0, 0, 1'b1);
        run_op(1'b0, 3'd2, 32'h0000_0044, 32'd0, 32'h1122_3344, 0, 0, 1'b1);
        chk("t6_b2b_rdata", lst_rdata, 32'h1122_3344);

        for (int i = 0; i < 200; i++) begin
            bit          wen;
            logic [2:0]  f3;
            wen = 1'($urandom_range(0, 1));
            f3  = wen ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            run_op(wen, f3, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
